// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline boundary with load formatting, 2-entry skid buffer and forwarding tap
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_alu_result,
    input  logic [DW-1:0] in_mem_rdata,
    input  logic          in_mem_to_reg,
    input  logic          in_reg_write,
    input  logic [RW-1:0] in_write_reg,
    input  logic [1:0]    in_ld_size,
    input  logic          in_ld_unsigned,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_alu_result,
    output logic [DW-1:0] out_mem_data,
    output logic          out_mem_to_reg,
    output logic          out_reg_write,
    output logic [RW-1:0] out_write_reg,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_reg,
    output logic [DW-1:0] fwd_data
);

    typedef struct packed {
        logic [DW-1:0] alu;
        logic [DW-1:0] mem;
        logic          m2r;
        logic          rw;
        logic [RW-1:0] rd;
    } entry_t;

    entry_t     head_q, head_d, skid_q, skid_d, new_e;
    logic [1:0] count_q, count_d;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] ld_fmt;
    logic          accept, consume;

    // Little-endian lane extraction; half ignores offset[0]
    always_comb begin
        byte_sel = in_mem_rdata[{in_alu_result[1:0], 3'b000} +: 8];
        half_sel = in_alu_result[1] ? in_mem_rdata[31:16] : in_mem_rdata[15:0];
        case (in_ld_size)
            2'b00:   ld_fmt = {{(DW-8){byte_sel[7] & ~in_ld_unsigned}}, byte_sel};
            2'b01:   ld_fmt = {{(DW-16){half_sel[15] & ~in_ld_unsigned}}, half_sel};
            default: ld_fmt = in_mem_rdata;
        endcase
        new_e.alu = in_alu_result;
        new_e.mem = ld_fmt;
        new_e.m2r = in_mem_to_reg;
        new_e.rw  = in_reg_write & (in_write_reg != '0);
        new_e.rd  = in_write_reg;
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign accept    = in_valid & in_ready;
    assign consume   = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case (count_q)
                2'd0: if (accept) begin
                    head_d  = new_e;
                    count_d = 2'd1;
                end
                2'd1: begin
                    if (accept && consume) begin
                        head_d = new_e;
                    end else if (accept) begin
                        skid_d  = new_e;
                        count_d = 2'd2;
                    end else if (consume) begin
                        count_d = 2'd0;
                    end
                end
                default: if (consume) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign out_alu_result = head_q.alu;
    assign out_mem_data   = head_q.mem;
    assign out_mem_to_reg = head_q.m2r;
    assign out_reg_write  = head_q.rw & out_valid;
    assign out_write_reg  = head_q.rd;
    assign fwd_valid      = out_reg_write;
    assign fwd_reg        = head_q.rd;
    assign fwd_data       = head_q.m2r ? head_q.mem : head_q.alu;

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - randomized self-checking bench for mem_wb_stage against a queue model
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_mem_rdata = '0;
    logic        in_mem_to_reg = 1'b0;
    logic        in_reg_write = 1'b0;
    logic [4:0]  in_write_reg = '0;
    logic [1:0]  in_ld_size = 2'b10;
    logic        in_ld_unsigned = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_alu_result;
    logic [31:0] out_mem_data;
    logic        out_mem_to_reg;
    logic        out_reg_write;
    logic [4:0]  out_write_reg;
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] mem;
        logic        m2r;
        logic        rw;
        logic [4:0]  rd;
    } exp_t;
    exp_t mq[$];

    mem_wb_stage #(.DW(32), .RW(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_write_reg(in_write_reg), .in_ld_size(in_ld_size),
        .in_ld_unsigned(in_ld_unsigned), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_result(out_alu_result), .out_mem_data(out_mem_data),
        .out_mem_to_reg(out_mem_to_reg), .out_reg_write(out_reg_write),
        .out_write_reg(out_write_reg),
        .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_fmt(logic [31:0] rdata, logic [31:0] addr,
                                              logic [1:0] sz, logic uns);
        int unsigned off = addr % 4;
        int unsigned v;
        if (sz == 2'd0) begin
            v = (rdata >> (8 * off)) % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (rdata >> ((off >= 2) ? 16 : 0)) % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rdata;
        end
        return v;
    endfunction

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] rdata,
                         input logic m2r, input logic rw, input logic [4:0] rd,
                         input logic [1:0] sz, input logic uns);
        in_valid = v; in_alu_result = alu; in_mem_rdata = rdata; in_mem_to_reg = m2r;
        in_reg_write = rw; in_write_reg = rd; in_ld_size = sz; in_ld_unsigned = uns;
    endtask

    // Advance one clock, updating the FIFO model from the inputs held across the edge
    task automatic tick();
        bit acc, cons;
        exp_t e;
        acc  = in_valid && (mq.size() < 2);
        cons = (mq.size() > 0) && out_ready;
        e.alu = in_alu_result;
        e.mem = model_fmt(in_mem_rdata, in_alu_result, in_ld_size, in_ld_unsigned);
        e.m2r = in_mem_to_reg;
        e.rw  = in_reg_write && (in_write_reg != 0);
        e.rd  = in_write_reg;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            if (cons) void'(mq.pop_front());
            if (acc) mq.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        checks++; if (out_alu_result !== 32'h0 || out_mem_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", out_alu_result, out_mem_data); end
        checks++; if (fwd_valid !== 1'b0 || out_reg_write !== 1'b0) begin failures++; $display("FAIL reset_fwd_valid got=%0b exp=0", fwd_valid); end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1, 32'h10, 32'h0, 0, 1, 5'd5, 2'b10, 0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_out_valid got=%0b exp=1", out_valid); end
        checks++; if (out_alu_result !== 32'h10) begin failures++; $display("FAIL basic_alu got=%h exp=00000010", out_alu_result); end
        checks++; if (fwd_valid !== 1'b1 || fwd_reg !== 5'd5) begin failures++; $display("FAIL basic_fwd got=%0b/%0d exp=1/5", fwd_valid, fwd_reg); end
        checks++; if (fwd_data !== 32'h10) begin failures++; $display("FAIL basic_fwd_data got=%h exp=00000010", fwd_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_load_format();
        logic [31:0] rdat [4] = '{32'h1280_3456, 32'h1280_3456, 32'h1280_3456, 32'h0000_8001};
        logic [31:0] addr [4] = '{32'h102, 32'h102, 32'h102, 32'h100};
        logic [1:0]  sz   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        uns  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] expv [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_1280, 32'hFFFF_8001};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1, addr[i], rdat[i], 1, 1, 5'd9, sz[i], uns[i]);
            tick();
            in_valid = 1'b0;
            checks++; if (out_mem_data !== expv[i] || fwd_data !== expv[i]) begin failures++; $display("FAIL load_fmt[%0d] got=%h fwd=%h exp=%h", i, out_mem_data, fwd_data, expv[i]); end
            tick();
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1, 32'hA, 32'h0, 0, 1, 5'd1, 2'b10, 0);
        tick();
        drive(1, 32'hB, 32'h0, 0, 1, 5'd2, 2'b10, 0);
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL skid_full_in_ready got=%0b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'hA) begin failures++; $display("FAIL skid_head got=%0b/%h exp=1/0000000a", out_valid, out_alu_result); end
        tick();
        checks++; if (out_alu_result !== 32'hA) begin failures++; $display("FAIL skid_hold got=%h exp=0000000a", out_alu_result); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'hB || in_ready !== 1'b1) begin failures++; $display("FAIL skid_second got=%0b/%h rdy=%0b exp=1/0000000b rdy=1", out_valid, out_alu_result, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL skid_empty got=%0b rdy=%0b exp=0 rdy=1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h100 + i, $urandom, 0, 1, 5'(i + 1), 2'b10, 0);
            tick();
            checks++; if (out_valid !== 1'b1 || out_alu_result !== 32'h100 + i || in_ready !== 1'b1) begin failures++; $display("FAIL b2b[%0d] got=%0b/%h rdy=%0b exp=1/%h rdy=1", i, out_valid, out_alu_result, in_ready, 32'h100 + i); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_end got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1, 32'h1, 32'h0, 0, 1, 5'd3, 2'b10, 0); tick();
        drive(1, 32'h2, 32'h0, 0, 1, 5'd4, 2'b10, 0); tick();
        drive(1, 32'hC, 32'h0, 0, 1, 5'd6, 2'b10, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0 || fwd_valid !== 1'b0 || out_reg_write !== 1'b0) begin failures++; $display("FAIL flush_full got=%0b/%0b exp=0/0", out_valid, fwd_valid); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%0b exp=1", in_ready); end
        // one held entry, flush with an acceptable input: the input is discarded too
        drive(1, 32'h7, 32'h0, 0, 1, 5'd7, 2'b10, 0); tick();
        drive(1, 32'hD, 32'h0, 0, 1, 5'd8, 2'b10, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL flush_discard got=%0b/%0b exp=0/0", out_valid, fwd_valid); end
    endtask

    task automatic test_r0();
        out_ready = 1'b1;
        drive(1, 32'h55, 32'h0, 0, 1, 5'd0, 2'b10, 0);
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || fwd_valid !== 1'b0) begin failures++; $display("FAIL r0_qual got=%0b/%0b/%0b exp=1/0/0", out_valid, out_reg_write, fwd_valid); end
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom),
                  5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 2'($urandom), 1'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush = $urandom_range(0, 24) == 0;
            tick();
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_flags c=%0d got v=%0b r=%0b exp count=%0d", c, out_valid, in_ready, mq.size());
            end else if (mq.size() > 0) begin
                if (out_alu_result !== mq[0].alu || out_mem_data !== mq[0].mem || out_mem_to_reg !== mq[0].m2r
                    || out_reg_write !== mq[0].rw || out_write_reg !== mq[0].rd || fwd_valid !== mq[0].rw
                    || fwd_reg !== mq[0].rd || fwd_data !== (mq[0].m2r ? mq[0].mem : mq[0].alu)) begin
                    failures++; bad++;
                    if (bad < 10) $display("FAIL rand_data c=%0d got alu=%h mem=%h rw=%0b rd=%0d exp alu=%h mem=%h rw=%0b rd=%0d",
                                           c, out_alu_result, out_mem_data, out_reg_write, out_write_reg,
                                           mq[0].alu, mq[0].mem, mq[0].rw, mq[0].rd);
                end
            end else if (out_reg_write !== 1'b0 || fwd_valid !== 1'b0) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_idle_we c=%0d got=%0b/%0b exp=0/0", c, out_reg_write, fwd_valid);
            end
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1, 32'hE1, 32'hFFFF_FFFF, 1, 1, 5'd10, 2'b10, 0); tick();
        drive(1, 32'hE2, 32'hFFFF_FFFF, 1, 1, 5'd11, 2'b10, 0); tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rstmid_pre got=%0b exp=0", in_ready); end
        #2 reset = 1'b1;
        #1;
        mq.delete();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_flags got=%0b/%0b exp=0/1", out_valid, in_ready); end
        checks++; if (out_alu_result !== 32'h0 || out_mem_data !== 32'h0 || fwd_data !== 32'h0 || fwd_valid !== 1'b0 || out_write_reg !== 5'd0) begin failures++; $display("FAIL rstmid_data got=%h/%h/%h/%0b exp=0", out_alu_result, out_mem_data, fwd_data, fwd_valid); end
        @(posedge clk); #1;
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after got=%0b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_load_format();
        test_skid();
        test_back_to_back();
        test_flush();
        test_r0();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM/WB pipeline boundary for the MIPS pipeline. Captures ALU result, raw data-memory read word and writeback control at the end of the MEM stage. Formats load data (byte/half/word, signed/unsigned) on capture and presents registered operands and select to the writeback mux.
Uses a 2-entry skid buffer with valid/ready handshake, so a writeback-side stall never drops an in-flight instruction. Also exports a forwarding tap for the hazard/forwarding unit.

Parameters:
DW, 32, datapath width (only 32 supported)
RW, 5, register-address width

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  MEM stage presents an instruction
in_ready  out  1  stage can accept (registered, = entry count < 2)
in_alu_result  in  DW  ALU result / effective address
in_mem_rdata  in  DW  raw aligned word from data memory
in_mem_to_reg  in  1  1 = write back memory data
in_reg_write  in  1  instruction writes register file
in_write_reg  in  RW  destination register
in_ld_size  in  2  00 byte, 01 half, 10 word, 11 treated as word
in_ld_unsigned  in  1  1 = zero-extend, 0 = sign-extend
flush  in  1  synchronous kill of all held entries
out_valid  out  1  head entry valid
out_ready  in  1  writeback consumes head this cycle
out_alu_result  out  DW  to writeback mux D0
out_mem_data  out  DW  formatted load data, to writeback mux D1
out_mem_to_reg  out  1  writeback mux select S
out_reg_write  out  1  register-file write enable (already qualified)
out_write_reg  out  RW  destination register
fwd_valid  out  1  out_valid & out_reg_write
fwd_reg  out  RW  = out_write_reg
fwd_data  out  DW  out_mem_to_reg ? out_mem_data : out_alu_result

Behaviour:
- Reset (async): entry count 0, in_ready=1, out_valid=0, all data/control outputs 0, fwd_valid=0.
- Handshakes: accept when in_valid & in_ready; consume when out_valid & out_ready. in_ready depends only on registered count, never on out_ready.
- Latency: empty stage, accepted at edge N, is visible on outputs after edge N (out_valid=1 in cycle N+1). Sustained throughput is 1/cycle while out_ready=1.
- Storage: head register drives outputs; skid register holds a second entry. Entry count is 0, 1 or 2.
- Accept into empty stage or with a simultaneous consume of a single entry: new entry goes to the head register.
- Accept while the head is held (out_ready=0, count 1): new entry goes to skid, count becomes 2, in_ready drops next cycle.
- Consume with count 2: skid moves to head. A simultaneous accept is impossible because in_ready=0.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- Load formatting, applied at capture, with offset = in_alu_result[1:0], little-endian lanes:
  - Byte: lane = offset, bits [8*offset+7 : 8*offset], extended to 32.
  - Half: offset[1] selects bits [31:16] or [15:0]; offset[0] is ignored; extended to 32.
  - Word: passed unchanged.
  - Formatting applies regardless of in_mem_to_reg; stored as out_mem_data.
- Register $0 qualification: captured reg_write = in_reg_write & (in_write_reg != 0).
- Flush: at the next edge count becomes 0 and out_valid=0. Any accept that same cycle is discarded. Flush beats accept and consume; in_ready=1 the following cycle. Data registers may keep stale values, but out_reg_write and fwd_valid read 0 whenever out_valid=0.
- Reset asserted mid-operation: immediate return to reset state, both entries lost.
- Outputs change only on clock edges, except fwd_* (combinational from registered head).

Test Plan:
- Reset, then in_valid=1 with alu=0x10, reg_write=1, rd=5, out_ready=1 -> out_valid=1 one cycle later; out_alu_result=0x10, fwd_valid=1, fwd_reg=5, fwd_data=0x10.
- Load byte signed, addr offset 2, rdata=0x1280_3456 -> out_mem_data=0xFFFF_FF80. Unsigned -> 0x0000_0080. Half signed, offset 2 -> 0x0000_1280. Half, offset 0, rdata 0x0000_8001 -> 0xFFFF_8001.
- out_ready=0, send A then B -> count 2, in_ready=0 after B. Release out_ready -> A then B on consecutive cycles, then in_ready=1.
- Back-to-back stream of 8 entries, out_ready=1 every cycle -> 8 consecutive out_valid cycles, in order, in_ready never drops.
- Two entries held, flush=1 together with in_valid=1 -> next cycle out_valid=0, fwd_valid=0, in_ready=1, flushed entry never appears.
- reg_write=1 with rd=0 -> out_reg_write=0, fwd_valid=0. Assert reset mid-stream with 2 entries -> outputs 0 immediately, without waiting for a clock edge.
